// File: rtl/ps2_kbd_ports.sv
// ps2_kbd_ports: memory-mapped PS/2 keyboard receiver with a small receive
// FIFO, sticky error flags and a level interrupt while bytes are pending.
module ps2_kbd_ports #(
    parameter int clk_freq   = 50000000,
    parameter int fifo_depth = 8,
    parameter int timeout_us = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    output logic        data_m_ack,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        ps2_intr
);
    localparam int AW  = $clog2(fifo_depth);
    localparam int TMO = clk_freq / 1000000 * timeout_us;
    localparam int TW  = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]    pclk_sync_q, pdat_sync_q;
    logic          pclk_filt_q;
    logic [1:0]    filt_cnt_q;
    logic          fall, dat;

    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d, stop_q, stop_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_req, perr_set, ferr_set;

    logic          ack_q, rd_q, pop_q, clr_q, req;
    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          perr_q, ferr_q, ovf_q, intr_q;
    logic          not_empty, full, pop, do_push, ovf_set;
    logic [7:0]    head;

    // The filtered clock flips on the 4th consecutive differing sample;
    // a falling edge is that flip from 1 to 0.
    assign dat  = pdat_sync_q[1];
    assign fall = pclk_filt_q && !pclk_sync_q[1] && (filt_cnt_q == 2'd3);

    // Synchronise both PS/2 lines and debounce the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_sync_q <= 2'b11;
            pdat_sync_q <= 2'b11;
            pclk_filt_q <= 1'b1;
            filt_cnt_q  <= 2'd0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[0], ps2_clk};
            pdat_sync_q <= {pdat_sync_q[0], ps2_dat};
            if (pclk_sync_q[1] == pclk_filt_q) begin
                filt_cnt_q <= 2'd0;
            end else if (filt_cnt_q == 2'd3) begin
                pclk_filt_q <= pclk_sync_q[1];
                filt_cnt_q  <= 2'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 2'd1;
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            tmo_q    <= tmo_d;
        end
    end

    // Receiver next state: collect 8 data bits LSB-first, parity, stop, then judge.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        stop_d   = stop_q;
        tmo_d    = tmo_q;
        push_req = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !dat) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd0;
                    tmo_d    = TW'(TMO);
                end
            end
            RECV: begin
                if (fall) begin
                    tmo_d    = TW'(TMO);
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        shreg_d = {dat, shreg_q[7:1]};
                    end else if (bitcnt_q == 4'd8) begin
                        par_d = dat;
                    end else begin
                        stop_d  = dat;
                        state_d = CHECK;
                    end
                end else if (tmo_q == '0) begin
                    state_d  = IDLE;
                    ferr_set = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (^{shreg_q, par_q} != 1'b1) begin
                    perr_set = 1'b1;
                end else if (!stop_q) begin
                    ferr_set = 1'b1;
                end else begin
                    push_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One ack per request: a request seen in the ack cycle is ignored.
    assign req       = cs && data_m_access && !ack_q;
    assign not_empty = (count_q != '0);
    assign full      = (count_q == (AW + 1)'(fifo_depth));
    assign pop       = pop_q && not_empty;
    assign do_push   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign head      = not_empty ? mem[rd_ptr_q] : 8'h00;

    assign data_m_ack      = ack_q;
    assign data_m_data_out = rd_q ? {3'b000, ovf_q, ferr_q, perr_q, full, not_empty, head} : 16'h0000;
    assign ps2_intr        = intr_q;

    // Bus handshake: capture the request, act on it in the ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            rd_q  <= 1'b0;
            pop_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ack_q <= req;
            rd_q  <= req && !data_m_wr_en;
            pop_q <= req && data_m_wr_en && data_m_bytesel[1] && data_m_data_in[15];
            clr_q <= req && data_m_wr_en && data_m_bytesel[1] && data_m_data_in[14];
        end
    end

    // FIFO pointers, occupancy, sticky flags and the interrupt level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            perr_q <= (perr_q && !clr_q) || perr_set;
            ferr_q <= (ferr_q && !clr_q) || ferr_set;
            ovf_q  <= (ovf_q && !clr_q) || ovf_set;
            intr_q <= not_empty;
        end
    end

    // FIFO storage; holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= shreg_q;
    end
endmodule
